// File: rtl/wishbone_pkg.sv
// Shared definitions for the Wishbone burst RAM: cycle/burst type codes, FSM states
// and the wrap-window mask helper used by the beat address generator.
package wishbone_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SINGLE,
        BURST
    } state_t;

    // Low address bits that roll over inside a wrapping burst; zero means linear.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        logic [3:0] mask;
        case (bte)
            BTE_WRAP4:  mask = 4'h3;
            BTE_WRAP8:  mask = 4'h7;
            BTE_WRAP16: mask = 4'hF;
            default:    mask = 4'h0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/wishbone_burst_addr.sv
// Next-beat address for an incrementing burst: linear increment with overflow flag,
// or wrap within a 4/8/16-word window keeping the upper address bits.
module wishbone_burst_addr
    import wishbone_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] beat_addr,
    input  logic [1:0]            bte,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  overflow
);

    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] incr;
    logic                  carry;

    always_comb begin
        mask          = ADDR_WIDTH'(wrap_mask(bte));
        {carry, incr} = {1'b0, beat_addr} + (ADDR_WIDTH+1)'(1);
        if (mask == '0) begin
            next_addr = incr;
            overflow  = carry;
        end else begin
            next_addr = (beat_addr & ~mask) | (incr & mask);
            overflow  = 1'b0;
        end
    end

endmodule

// File: rtl/wishbone_burst_ram.sv
// Wishbone B4 registered-feedback RAM slave with byte selects, CTI/BTE bursts and range ERR.
// Define WISHBONE_BURST_RAM_INIT_EN to fill ram[i]=i after every reset before serving the bus.
module wishbone_burst_ram
    import wishbone_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [29:0]             addr,
    input  logic [1:0]              bte,
    input  logic [2:0]              cti,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   data_write,
    output logic                    ack,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   data_read
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
`ifdef WISHBONE_BURST_RAM_INIT_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_read_q, data_read_d;
    logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
`ifdef WISHBONE_BURST_RAM_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`endif

    logic [ADDR_WIDTH-1:0] addr_low, next_addr, read_addr, mem_addr;
    logic                  overflow, req, xfer, in_range, is_incr, is_eob;
    logic                  mem_we;
    logic [SEL_WIDTH-1:0]  mem_sel;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign addr_low  = addr[ADDR_WIDTH-1:0];
    assign in_range  = (addr[29:ADDR_WIDTH] == '0);
    assign req       = cyc & stb;
    assign xfer      = req & ack_q;
    assign is_incr   = (cti == CTI_INCR);
    assign is_eob    = (cti == CTI_EOB);
    assign ack       = ack_q;
    assign err       = err_q;
    assign data_read = data_read_q;

    wishbone_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_addr (
        .beat_addr (beat_addr_q),
        .bte       (bte),
        .next_addr (next_addr),
        .overflow  (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            data_read_q <= '0;
            beat_addr_q <= '0;
`ifdef WISHBONE_BURST_RAM_INIT_EN
            init_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            data_read_q <= data_read_d;
            beat_addr_q <= beat_addr_d;
`ifdef WISHBONE_BURST_RAM_INIT_EN
            init_cnt_q  <= init_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef WISHBONE_BURST_RAM_INIT_EN
            INIT:    if (init_cnt_q == '1) state_d = IDLE;
`else
            INIT:    state_d = IDLE;
`endif
            IDLE:    if (req) state_d = (in_range && is_incr) ? BURST : SINGLE;
            SINGLE:  state_d = IDLE;
            BURST: begin
                if (xfer) begin
                    if (is_eob)        state_d = IDLE;
                    else if (overflow) state_d = SINGLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!cyc && state_q != INIT) state_d = IDLE;
    end

    // Read data is fetched one beat ahead so ack can stay high on consecutive beats.
    always_comb begin
        ack_d       = 1'b0;
        err_d       = 1'b0;
        beat_addr_d = beat_addr_q;
        read_addr   = beat_addr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d     = 1'b1;
                        read_addr = addr_low;
                        if (is_incr) beat_addr_d = addr_low;
                    end
                end
            end
            BURST: begin
                if (xfer) begin
                    if (!is_eob) begin
                        if (overflow) begin
                            err_d = 1'b1;
                        end else begin
                            ack_d       = 1'b1;
                            beat_addr_d = next_addr;
                            read_addr   = next_addr;
                        end
                    end
                end else if (!ack_q && req) begin
                    ack_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (!cyc) begin
            ack_d = 1'b0;
            err_d = 1'b0;
        end
        data_read_d = ack_d ? mem[read_addr] : data_read_q;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_sel   = '1;
        mem_addr  = (state_q == BURST) ? beat_addr_q : addr_low;
        mem_wdata = data_write;
        if (xfer && we && (state_q == SINGLE || state_q == BURST)) begin
            mem_we  = 1'b1;
            mem_sel = sel;
        end
`ifdef WISHBONE_BURST_RAM_INIT_EN
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            mem_we     = 1'b1;
            mem_addr   = init_cnt_q;
            mem_wdata  = DATA_WIDTH'(init_cnt_q);
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        end
`endif
        if (reset) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (mem_sel[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wishbone_burst_ram.sv
// Scoreboard bench for wishbone_burst_ram: directed scenarios plus random classic/burst traffic
// checked against a word-array reference model; follows WISHBONE_BURST_RAM_INIT_EN if defined.
module tb_wishbone_burst_ram;
    import wishbone_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] data_write;
    logic        ack, err;
    logic [31:0] data_read;

    typedef struct {
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    wishbone_burst_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .bte        (bte),
        .cti        (cti),
        .cyc        (cyc),
        .stb        (stb),
        .we         (we),
        .sel        (sel),
        .data_write (data_write),
        .ack        (ack),
        .err        (err),
        .data_read  (data_read)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    // Word address of beat k: linear counts up without limit, wrap stays inside its aligned window.
    function automatic int beatAddr(input int start, input logic [1:0] b, input int k);
        int w;
        if (b == BTE_LINEAR) return start + k;
        w = (b == BTE_WRAP4) ? 4 : (b == BTE_WRAP8) ? 8 : 16;
        return (start - (start % w)) + ((start % w) + k) % w;
    endfunction

    task automatic pushExp(input bit is_err, input bit is_read, input logic [31:0] d);
        exp_t e;
        e.is_err  = is_err;
        e.is_read = is_read;
        e.data    = d;
        sb.push_back(e);
    endtask

    task automatic driveIdle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        sel = 4'h0; addr = '0; data_write = '0;
    endtask

    task automatic postReset();
`ifdef WISHBONE_BURST_RAM_INIT_EN
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
`else
        @(posedge clk);
        #1;
`endif
    endtask

    // Classic single transfer; a >= DEPTH expects an error response.
    task automatic applyStimulus(input int a, input bit w, input logic [31:0] d, input logic [3:0] s);
        int  n;
        bit  oor;
        oor = (a >= DEPTH);
        if (oor) pushExp(1'b1, !w, 32'h0);
        else     pushExp(1'b0, !w, model[a]);
        addr = 30'(a); we = w; data_write = d; sel = s; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(ack || err) && n < 20);
        if (!(ack || err)) begin
            checks++; errors++;
            $display("[TB] FAIL classic_timeout: no response after %0d cycles, expected 1", n);
            sb.delete();
            driveIdle();
            return;
        end
        checkOutput("classic_latency", n, 1);
        @(posedge clk);
        #1;
        if (w && !oor) model[a] = mergeBytes(model[a], d, s);
        driveIdle();
        checkOutput("classic_resp_drop", {ack, err}, 2'b00);
    endtask

    task automatic runBurst(input int start, input logic [1:0] b, input int n, input bit w,
                            input int gap_beat, input int gap_len, input int reset_beat);
        int          edges, beats, a, guard;
        bit          beat_err;
        logic [31:0] wd;
        logic [3:0]  ws;
        edges = 0; beats = 0;
        cyc = 1'b1; stb = 1'b1; we = w; bte = b;
        for (int k = 0; k < n; k++) begin
            a = beatAddr(start, b, k);
            if (k > 0 && k == gap_beat && gap_len > 0) begin
                stb = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                    edges++;
                end
                stb = 1'b1;
            end
            wd = $urandom;
            ws = 4'($urandom_range(1, 15));
            addr = 30'(a); cti = (k == n - 1) ? CTI_EOB : CTI_INCR; data_write = wd; sel = ws;
            beat_err = (a >= DEPTH);
            if (beat_err) pushExp(1'b1, !w, 32'h0);
            else          pushExp(1'b0, !w, model[a]);
            if (k == reset_beat) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("reset_mid_burst_out", {ack, err, data_read}, 34'h0);
                driveIdle();
                reset = 1'b0;
                sb.delete();
                postReset();
                return;
            end
            guard = 0;
            while (!(ack || err) && guard < 20) begin
                @(posedge clk);
                #1;
                edges++;
                guard++;
            end
            if (!(ack || err)) begin
                checks++; errors++;
                $display("[TB] FAIL burst_timeout: beat %0d got no response, expected ack or err", k);
                sb.delete();
                driveIdle();
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            edges++;
            beats++;
            if (w && !beat_err) model[a] = mergeBytes(model[a], wd, ws);
            if (beat_err) break;
        end
        driveIdle();
        checkOutput("burst_end_quiet", {ack, err}, 2'b00);
        if (gap_len == 0) checkOutput("burst_cycles", edges, beats + 1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a response counts only when the master is strobing.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (ack || err)) begin
            checkOutput("ack_err_exclusive", {ack, err} == 2'b11, 1'b0);
            if (cyc && stb) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_resp: ack=%0b err=%0b with no pending transfer", ack, err);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_kind", {ack, err}, e.is_err ? 2'b01 : 2'b10);
                    if (e.is_read && !e.is_err) checkOutput("read_data", data_read, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind, a, n, gb, gl;
        driveIdle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ack", ack, 1'b0);
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_data_read", data_read, 32'h0);
        reset = 1'b0;
        postReset();

`ifndef WISHBONE_BURST_RAM_INIT_EN
        for (int i = 0; i < DEPTH; i++) applyStimulus(i, 1'b1, 32'(i), 4'hF);
`endif

        $display("[TB] directed scenarios");
        applyStimulus(5, 1'b0, 32'h0, 4'h0);
        applyStimulus(3, 1'b1, 32'hAABBCCDD, 4'b0101);
        applyStimulus(3, 1'b0, 32'h0, 4'h0);
        checkOutput("byte_merge_model", model[3], 32'h00BB00DD);
        runBurst(6, BTE_WRAP4, 4, 1'b0, -1, 0, -1);
        runBurst(14, BTE_LINEAR, 3, 1'b0, -1, 0, -1);
        applyStimulus(16, 1'b0, 32'h0, 4'h0);
        runBurst(0, BTE_LINEAR, 5, 1'b0, 2, 2, -1);
        runBurst(8, BTE_WRAP8, 6, 1'b1, -1, 0, -1);
        runBurst(8, BTE_WRAP8, 8, 1'b0, -1, 0, -1);
        runBurst(4, BTE_LINEAR, 8, 1'b1, -1, 0, 3);
        for (int i = 4; i < 8; i++) applyStimulus(i, 1'b0, 32'h0, 4'h0);

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                a = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
                applyStimulus(a, $urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                n  = $urandom_range(1, 8);
                gb = -1;
                gl = 0;
                if (n > 1 && $urandom_range(0, 2) == 0) begin
                    gb = $urandom_range(1, n - 1);
                    gl = $urandom_range(1, 3);
                end
                runBurst($urandom_range(0, 15), 2'($urandom_range(0, 3)), n,
                         $urandom_range(0, 1) == 1, gb, gl, -1);
            end
        end
        for (int i = 0; i < DEPTH; i++) applyStimulus(i, 1'b0, 32'h0, 4'h0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
